// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS main control unit.
// Holds the state encoding, supported opcodes, ALUOp codes and the control word layout.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       branch;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational control-word decoder: current state, opcode and memory-ready in,
// datapath selects and enables out. Unlisted outputs default to 0.
module mips_ctrl_outdec
  import mips_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output ctrl_t              ctrl
);

  always_comb begin
    ctrl = '0;
    case (state_t'(state))
      FETCH: begin
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        // Branch target is precomputed here so BRANCH only needs the compare.
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALUOP_ADD;
        if (!op_is_legal(op)) begin
          ctrl.illegal_op = 1'b1;
          ctrl.instr_done = 1'b1;
        end
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMREAD: begin
        ctrl.iord = 1'b1;
      end
      MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEMWRITE: begin
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b00;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = 2'b00;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_src     = 2'b01;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      JUMP: begin
        ctrl.pc_src     = 2'b10;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_main_control_fsm.sv
// Multicycle MIPS main control FSM: state register and next-state logic, with the
// control word produced by mips_ctrl_outdec and write enables masked during reset.
module mips_main_control_fsm
  import mips_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] Op,
  input  logic            MemReady,
  output logic            IorD,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      PCSrc,
  output logic [1:0]      ALUOp,
  output logic            PCWrite,
  output logic            Branch,
  output logic            InstrDone,
  output logic            IllegalOp
);

  logic [STATE_W-1:0] state_reg;
  ctrl_t              ctrl_dec;
  ctrl_t              ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= STATE_W'(FETCH);
    end else begin
      case (state_t'(state_reg))
        FETCH:    if (MemReady) state_reg <= STATE_W'(DECODE);
        DECODE: begin
          case (Op)
            OP_LW, OP_SW: state_reg <= STATE_W'(MEMADR);
            OP_RTYPE:     state_reg <= STATE_W'(EXECUTE);
            OP_BEQ:       state_reg <= STATE_W'(BRANCH);
            OP_ADDI:      state_reg <= STATE_W'(ADDIEX);
            OP_J:         state_reg <= STATE_W'(JUMP);
            default:      state_reg <= STATE_W'(FETCH);
          endcase
        end
        MEMADR:   state_reg <= (Op == OP_SW) ? STATE_W'(MEMWRITE) : STATE_W'(MEMREAD);
        MEMREAD:  if (MemReady) state_reg <= STATE_W'(MEMWB);
        MEMWRITE: if (MemReady) state_reg <= STATE_W'(FETCH);
        EXECUTE:  state_reg <= STATE_W'(ALUWB);
        ADDIEX:   state_reg <= STATE_W'(ADDIWB);
        default:  state_reg <= STATE_W'(FETCH);
      endcase
    end
  end

  mips_ctrl_outdec #(
    .OP_W    (OP_W),
    .STATE_W (STATE_W)
  ) u_outdec (
    .state     (state_reg),
    .op        (Op),
    .mem_ready (MemReady),
    .ctrl      (ctrl_dec)
  );

  // The state is already FETCH while rst_n is low; only side-effecting strobes need masking.
  always_comb begin
    ctrl = ctrl_dec;
    if (!rst_n) begin
      ctrl.mem_write  = 1'b0;
      ctrl.ir_write   = 1'b0;
      ctrl.reg_write  = 1'b0;
      ctrl.pc_write   = 1'b0;
      ctrl.branch     = 1'b0;
      ctrl.instr_done = 1'b0;
      ctrl.illegal_op = 1'b0;
    end
  end

  assign IorD      = ctrl.iord;
  assign MemWrite  = ctrl.mem_write;
  assign IRWrite   = ctrl.ir_write;
  assign RegDst    = ctrl.reg_dst;
  assign MemtoReg  = ctrl.mem_to_reg;
  assign RegWrite  = ctrl.reg_write;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign PCSrc     = ctrl.pc_src;
  assign ALUOp     = ctrl.alu_op;
  assign PCWrite   = ctrl.pc_write;
  assign Branch    = ctrl.branch;
  assign InstrDone = ctrl.instr_done;
  assign IllegalOp = ctrl.illegal_op;

endmodule

// File: tb/tb_mips_main_control_fsm.sv
// Scoreboard bench for mips_main_control_fsm: the driver pushes the expected control
// word for every cycle from a per-instruction cycle script; a monitor compares at negedge.
`timescale 1ns/1ps
module tb_mips_main_control_fsm;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       branch;
    logic       instr_done;
    logic       illegal_op;
  } exp_t;

  typedef struct {
    exp_t  exp;
    string tag;
  } sb_item_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] Op;
  logic       MemReady;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc, ALUOp;
  logic       PCWrite, Branch, InstrDone, IllegalOp;

  sb_item_t sb[$];
  int       checks   = 0;
  int       failures = 0;
  exp_t     actual;

  mips_main_control_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Op        (Op),
    .MemReady  (MemReady),
    .IorD      (IorD),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .PCSrc     (PCSrc),
    .ALUOp     (ALUOp),
    .PCWrite   (PCWrite),
    .Branch    (Branch),
    .InstrDone (InstrDone),
    .IllegalOp (IllegalOp)
  );

  assign actual = '{IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                    ALUSrcB, PCSrc, ALUOp, PCWrite, Branch, InstrDone, IllegalOp};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: one expected word per cycle, compared away from the rising edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_item_t it;
      it = sb.pop_front();
      checks++;
      if (actual !== it.exp) begin
        failures++;
        $display("FAIL %s t=%0t actual=%b required=%b (Op=%b MemReady=%b)",
                 it.tag, $time, actual, it.exp, Op, MemReady);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", sb.size());
    $fatal(1, "watchdog");
  end

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic logic [5:0] kind_op(input int kind);
    logic [5:0] op;
    case (kind)
      0: op = 6'b000000;
      1: op = 6'b100011;
      2: op = 6'b101011;
      3: op = 6'b000100;
      4: op = 6'b001000;
      5: op = 6'b000010;
      default: begin
        op = 6'($urandom);
        while (legal(op)) op = 6'($urandom);
      end
    endcase
    return op;
  endfunction

  task automatic step(input logic [5:0] op, input logic mr, input exp_t e, input string tag);
    sb_item_t it;
    Op       = op;
    MemReady = mr;
    it.exp   = e;
    it.tag   = tag;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t fetch_word(input logic ready);
    exp_t e = '0;
    e.alu_src_b = 2'b01;
    e.ir_write  = ready;
    e.pc_write  = ready;
    return e;
  endfunction

  function automatic exp_t rb();
    return 1'($urandom);
  endfunction

  // Fetch and decode phases shared by every instruction.
  task automatic fetch_decode(input logic [5:0] op, input int fw);
    exp_t e;
    for (int i = 0; i < fw; i++) step(6'($urandom), 1'b0, fetch_word(1'b0), "fetch_wait");
    step(6'($urandom), 1'b1, fetch_word(1'b1), "fetch_go");
    e = '0;
    e.alu_src_b = 2'b11;
    if (!legal(op)) begin
      e.instr_done = 1'b1;
      e.illegal_op = 1'b1;
    end
    step(op, 1'($urandom), e, legal(op) ? "decode" : "decode_illegal");
  endtask

  task automatic run_instr(input int kind, input logic [5:0] op, input int fw, input int mw);
    exp_t e;
    fetch_decode(op, fw);
    case (kind)
      0: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b10;
        step(op, 1'($urandom), e, "rtype_exec");
        e = '0; e.reg_dst = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
        step(op, 1'($urandom), e, "rtype_wb");
      end
      1, 2: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        step(op, 1'($urandom), e, "memadr");
        e = '0; e.iord = 1'b1; e.mem_write = (kind == 2);
        for (int i = 0; i < mw; i++) step(op, 1'b0, e, "mem_wait");
        e.instr_done = (kind == 2);
        step(op, 1'b1, e, "mem_go");
        if (kind == 1) begin
          e = '0; e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
          step(op, 1'($urandom), e, "lw_wb");
        end
      end
      3: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01;
        e.branch = 1'b1; e.instr_done = 1'b1;
        step(op, 1'($urandom), e, "beq");
      end
      4: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        step(op, 1'($urandom), e, "addi_exec");
        e = '0; e.reg_write = 1'b1; e.instr_done = 1'b1;
        step(op, 1'($urandom), e, "addi_wb");
      end
      5: begin
        e = '0; e.pc_src = 2'b10; e.pc_write = 1'b1; e.instr_done = 1'b1;
        step(op, 1'($urandom), e, "jump");
      end
      default: ;
    endcase
  endtask

  initial begin
    exp_t e;
    rst_n    = 1'b0;
    Op       = 6'b0;
    MemReady = 1'b0;
    @(posedge clk);
    #1;
    // Reset holds FETCH selects with every strobe masked, even with MemReady high.
    step(6'($urandom), 1'b1, fetch_word(1'b0), "reset_state");
    step(6'($urandom), 1'b0, fetch_word(1'b0), "reset_state");
    rst_n = 1'b1;

    run_instr(0, 6'b000000, 0, 0);
    run_instr(1, 6'b100011, 0, 3);
    run_instr(2, 6'b101011, 1, 2);
    run_instr(3, 6'b000100, 0, 0);
    run_instr(5, 6'b000010, 0, 0);
    run_instr(6, 6'b111111, 0, 0);
    run_instr(4, 6'b001000, 2, 0);

    // Abort a store while it is waiting on memory.
    fetch_decode(6'b101011, 0);
    e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
    step(6'b101011, 1'b0, e, "memadr");
    e = '0; e.iord = 1'b1; e.mem_write = 1'b1;
    step(6'b101011, 1'b0, e, "mem_wait");
    rst_n = 1'b0;
    step(6'b101011, 1'b1, fetch_word(1'b0), "reset_mid_sw");
    step(6'b101011, 1'b1, fetch_word(1'b0), "reset_mid_sw");
    rst_n = 1'b1;
    run_instr(0, 6'b000000, 0, 0);

    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 6);
      run_instr(kind, kind_op(kind), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0 pending entries", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
